// File: rtl/fwd_sel_ctrl.sv
// Operand-forwarding select generator and load-use stall controller for the
// 6-stage pipeline: tracks EX/MEM/WB destinations and registers EX bypass selects.
module fwd_sel_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rr_valid,
  input  logic [REG_AW-1:0] rr_rs1,
  input  logic [REG_AW-1:0] rr_rs2,
  input  logic [REG_AW-1:0] rr_rd,
  input  logic              rr_we,
  input  logic              rr_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic              stall,
  output logic              fwd_a_mem,
  output logic              fwd_a_wb,
  output logic              fwd_a_late,
  output logic              fwd_b_mem,
  output logic              fwd_b_wb,
  output logic              fwd_b_late,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } trk_t;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam trk_t TRK_EMPTY = '{valid: 1'b0, rd: {REG_AW{1'b0}}, we: 1'b0, is_load: 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  trk_t             ex_q, ex_d;
  trk_t             mem_q, mem_d;
  trk_t             wb_q, wb_d;
  logic [2:0]       sel_a_q, sel_a_d;  // {mem, wb, late}
  logic [2:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_c;
  logic             issue_c;
  trk_t             rr_entry_c;
  logic             unused_c;

  function automatic logic writes_reg(input trk_t e, input logic [REG_AW-1:0] r);
    return e.valid & e.we & (e.rd == r) & (r != REG_ZERO);
  endfunction

  // Youngest in-flight writer wins; at most one select is ever set.
  function automatic logic [2:0] bypass_sel(input logic [REG_AW-1:0] s,
                                            input trk_t ex_e,
                                            input trk_t mem_e,
                                            input trk_t wb_e);
    logic [2:0] sel;
    if (writes_reg(ex_e, s)) begin
      sel = 3'b100;
    end else if (writes_reg(mem_e, s)) begin
      sel = 3'b010;
    end else if (writes_reg(wb_e, s)) begin
      sel = 3'b001;
    end else begin
      sel = 3'b000;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction currently in EX.
  always_comb begin
    stall_c = 1'b0;
    if (!flush && rr_valid && ex_q.is_load &&
        (writes_reg(ex_q, rr_rs1) || writes_reg(ex_q, rr_rs2))) begin
      stall_c = 1'b1;
    end else begin
      stall_c = 1'b0;
    end
  end

  assign issue_c    = rr_valid & ~stall_c & ~flush;
  assign rr_entry_c = '{valid: 1'b1, rd: rr_rd, we: rr_we, is_load: rr_is_load};
  assign unused_c   = wb_q.is_load;

  // Tracker shift and select generation; a flush also kills the EX
  // instruction, so it never reaches MEM and cannot be forwarded later.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!hold) begin
      wb_d = mem_q;
      if (flush) begin
        mem_d   = TRK_EMPTY;
        ex_d    = TRK_EMPTY;
        sel_a_d = 3'b000;
        sel_b_d = 3'b000;
      end else begin
        mem_d = ex_q;
        if (issue_c) begin
          ex_d    = rr_entry_c;
          sel_a_d = bypass_sel(rr_rs1, ex_q, mem_q, wb_q);
          sel_b_d = bypass_sel(rr_rs2, ex_q, mem_q, wb_q);
        end else begin
          ex_d    = TRK_EMPTY;
          sel_a_d = 3'b000;
          sel_b_d = 3'b000;
        end
      end
    end else begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      wb_d    = wb_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
    end
  end

  // Saturating count of stall cycles that actually cost an edge.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && !hold && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= TRK_EMPTY;
      mem_q       <= TRK_EMPTY;
      wb_q        <= TRK_EMPTY;
      sel_a_q     <= 3'b000;
      sel_b_q     <= 3'b000;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall      = stall_c;
  assign fwd_a_mem  = sel_a_q[2];
  assign fwd_a_wb   = sel_a_q[1];
  assign fwd_a_late = sel_a_q[0];
  assign fwd_b_mem  = sel_b_q[2];
  assign fwd_b_wb   = sel_b_q[1];
  assign fwd_b_late = sel_b_q[0];
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Self-checking bench for fwd_sel_ctrl: directed scenarios plus random traffic
// scored against an instruction-level pipeline model.
module tb_fwd_sel_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          rr_valid, rr_we, rr_is_load, hold, flush;
  logic [AW-1:0] rr_rs1, rr_rs2, rr_rd;
  logic          stall;
  logic          fwd_a_mem, fwd_a_wb, fwd_a_late, fwd_b_mem, fwd_b_wb, fwd_b_late;
  logic [CW-1:0] stall_cnt;
  logic [5:0]    dut_sel;

  fwd_sel_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_rs1(rr_rs1), .rr_rs2(rr_rs2),
    .rr_rd(rr_rd), .rr_we(rr_we), .rr_is_load(rr_is_load), .hold(hold), .flush(flush),
    .stall(stall), .fwd_a_mem(fwd_a_mem), .fwd_a_wb(fwd_a_wb), .fwd_a_late(fwd_a_late),
    .fwd_b_mem(fwd_b_mem), .fwd_b_wb(fwd_b_wb), .fwd_b_late(fwd_b_late),
    .stall_cnt(stall_cnt)
  );

  assign dut_sel = {fwd_a_mem, fwd_a_wb, fwd_a_late, fwd_b_mem, fwd_b_wb, fwd_b_late};

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: list of in-flight instructions by age, 0 = in EX, 1 = MEM, 2 = WB.
  typedef struct {bit v; int rd; bit we; bit ld;} ins_t;
  ins_t     pipe[3];
  bit [5:0] m_sel;
  int       m_cnt;
  bit       last_stall;
  logic     obs_stall;

  function automatic bit [2:0] ref_sel(int s);
    for (int d = 0; d < 3; d++)
      if (pipe[d].v && pipe[d].we && pipe[d].rd == s && s != 0) return 3'(3'b100 >> d);
    return 3'b000;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 0, 1'b0, 1'b0};
    m_sel = 6'b0;
    m_cnt = 0;
  endtask

  // One pipeline cycle: drive RR, check stall, clock, check selects and counter.
  task automatic step(input bit rv, input int rs1, input int rs2, input int rd,
                      input bit we, input bit ld, input bit hl, input bit fl);
    ins_t     nx[3];
    bit [5:0] nsel;
    int       ncnt;
    bit       exp_stall;
    rr_valid = rv; rr_rs1 = AW'(rs1); rr_rs2 = AW'(rs2); rr_rd = AW'(rd);
    rr_we = we; rr_is_load = ld; hold = hl; flush = fl;
    #1;
    exp_stall = rv && !fl && pipe[0].v && pipe[0].ld && pipe[0].we && pipe[0].rd != 0 &&
                (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    obs_stall = stall;
    total++;
    if (stall !== exp_stall) begin
      bad++;
      $display("FAIL stall t=%0t got=%b want=%b", $time, stall, exp_stall);
    end
    last_stall = exp_stall;
    nx = pipe; nsel = m_sel; ncnt = m_cnt;
    if (!hl) begin
      nx[2] = pipe[1];
      if (fl) begin
        nx[1] = '{1'b0, 0, 1'b0, 1'b0};
        nx[0] = '{1'b0, 0, 1'b0, 1'b0};
        nsel = 6'b0;
      end else begin
        nx[1] = pipe[0];
        if (rv && !exp_stall) begin
          nx[0] = '{1'b1, rd, we, ld};
          nsel = {ref_sel(rs1), ref_sel(rs2)};
        end else begin
          nx[0] = '{1'b0, 0, 1'b0, 1'b0};
          nsel = 6'b0;
        end
      end
      if (exp_stall && ncnt < CNT_MAX) ncnt++;
    end
    @(posedge clk);
    #1;
    pipe = nx; m_sel = nsel; m_cnt = ncnt;
    total++;
    if (dut_sel !== m_sel) begin
      bad++;
      $display("FAIL selects t=%0t got=%b want=%b", $time, dut_sel, m_sel);
    end
    total++;
    if (stall_cnt !== CW'(m_cnt)) begin
      bad++;
      $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, m_cnt);
    end
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input bit we, input bit ld);
    int n = 0;
    do begin
      step(1'b1, rs1, rs2, rd, we, ld, 1'b0, 1'b0);
      n++;
    end while (last_stall && n < 3);
    if (last_stall) begin
      total++; bad++;
      $display("FAIL issue_timeout t=%0t stall still high after %0d cycles", $time, n);
    end
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rr_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rr_valid = 1'b1; rr_rs1 = 5'd3; rr_rs2 = 5'd4; rr_rd = 5'd5; rr_we = 1'b1; rr_is_load = 1'b1;
    do_reset();
    total++;
    if ({stall, dut_sel, stall_cnt} !== {1'b0, 6'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_state got stall=%b sel=%b cnt=%0d want all zero", stall, dut_sel, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    issue(0, 0, 5, 1'b1, 1'b0);
    issue(5, 0, 1, 1'b0, 1'b0);
    total++;
    if (dut_sel !== 6'b100000) begin
      bad++; $display("FAIL back_to_back got=%b want=100000", dut_sel);
    end
  endtask

  task automatic test_distance();
    logic [5:0] exp;
    for (int gap = 1; gap <= 3; gap++) begin
      drain();
      issue(0, 0, 7, 1'b1, 1'b0);
      repeat (gap) issue(0, 0, 1, 1'b0, 1'b0);
      issue(0, 7, 2, 1'b0, 1'b0);
      case (gap)
        1: exp = 6'b000010;
        2: exp = 6'b000001;
        default: exp = 6'b000000;
      endcase
      total++;
      if (dut_sel !== exp) begin
        bad++; $display("FAIL distance_gap%0d got=%b want=%b", gap, dut_sel, exp);
      end
    end
  endtask

  task automatic test_priority();
    drain();
    issue(0, 0, 3, 1'b1, 1'b0);
    issue(0, 0, 3, 1'b1, 1'b0);
    issue(3, 0, 1, 1'b0, 1'b0);
    total++;
    if (dut_sel !== 6'b100000) begin
      bad++; $display("FAIL priority got=%b want=100000", dut_sel);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(0, 0, 9, 1'b1, 1'b1);
    step(1'b1, 0, 9, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({obs_stall, dut_sel, stall_cnt} !== {1'b1, 6'b0, 4'd1}) begin
      bad++;
      $display("FAIL load_use_bubble got stall=%b sel=%b cnt=%0d want 1/000000/1", obs_stall, dut_sel, stall_cnt);
    end
    step(1'b1, 0, 9, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({obs_stall, dut_sel, stall_cnt} !== {1'b0, 6'b000010, 4'd1}) begin
      bad++;
      $display("FAIL load_use_fwd got stall=%b sel=%b cnt=%0d want 0/000010/1", obs_stall, dut_sel, stall_cnt);
    end
    issue(0, 0, 11, 1'b1, 1'b1);
    issue(0, 0, 1, 1'b0, 1'b0);
    step(1'b1, 11, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({obs_stall, dut_sel} !== {1'b0, 6'b010000}) begin
      bad++; $display("FAIL load_in_mem got stall=%b sel=%b want 0/010000", obs_stall, dut_sel);
    end
  endtask

  task automatic test_flush_hold();
    int cnt0;
    drain();
    issue(0, 0, 4, 1'b1, 1'b0);
    step(1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4, 4, 1, 1'b0, 1'b0);
    total++;
    if (dut_sel !== 6'b0) begin
      bad++; $display("FAIL flush_kill got=%b want=000000", dut_sel);
    end
    drain();
    issue(0, 0, 4, 1'b1, 1'b0);
    step(1'b1, 4, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4, 0, 1, 1'b0, 1'b0);
    total++;
    if (dut_sel !== 6'b0) begin
      bad++; $display("FAIL flush_under_hold got=%b want=000000", dut_sel);
    end
    drain();
    issue(0, 0, 6, 1'b1, 1'b0);
    issue(6, 0, 12, 1'b1, 1'b1);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if ({obs_stall, dut_sel, stall_cnt} !== {1'b1, 6'b100000, CW'(cnt0)}) begin
        bad++;
        $display("FAIL hold_freeze%0d got stall=%b sel=%b cnt=%0d want 1/100000/%0d", i, obs_stall, dut_sel, stall_cnt, cnt0);
      end
    end
    issue(12, 0, 1, 1'b0, 1'b0);
    total++;
    if (dut_sel !== 6'b010000) begin
      bad++; $display("FAIL hold_release got=%b want=010000", dut_sel);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(0, 0, 9, 1'b1, 1'b1);
    issue(0, 9, 1, 1'b0, 1'b0);
    issue(0, 0, 10, 1'b1, 1'b1);
    rr_valid = 1'b1; rr_rs1 = 5'd10; rr_rs2 = 5'd0; rr_rd = 5'd2; rr_we = 1'b0; rr_is_load = 1'b0;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL pre_reset_stall got=%b want=1", stall);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({stall, dut_sel, stall_cnt} !== {1'b0, 6'b0, 4'd0}) begin
      bad++;
      $display("FAIL async_reset got stall=%b sel=%b cnt=%0d want all zero", stall, dut_sel, stall_cnt);
    end
    model_clear();
    rr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 10, 9, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({obs_stall, dut_sel} !== {1'b0, 6'b0}) begin
      bad++; $display("FAIL post_reset_empty got stall=%b sel=%b want 0/000000", obs_stall, dut_sel);
    end
  endtask

  task automatic test_x0();
    drain();
    issue(0, 0, 0, 1'b1, 1'b0);
    issue(0, 0, 1, 1'b0, 1'b0);
    total++;
    if (dut_sel !== 6'b0) begin
      bad++; $display("FAIL x0_alu got=%b want=000000", dut_sel);
    end
    issue(0, 0, 0, 1'b1, 1'b1);
    step(1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({obs_stall, dut_sel} !== {1'b0, 6'b0}) begin
      bad++; $display("FAIL x0_load got stall=%b sel=%b want 0/000000", obs_stall, dut_sel);
    end
  endtask

  task automatic test_random();
    bit rv, we, ld, hl, fl;
    int rs1, rs2, rd;
    bit need_new = 1'b1;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (need_new) begin
        rv = ($urandom_range(0, 7) != 0);
        rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        we = ($urandom_range(0, 3) != 0); ld = ($urandom_range(0, 2) == 0);
      end
      hl = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 14) == 0);
      step(rv, rs1, rs2, rd, we, ld, hl, fl);
      need_new = !hl && (fl || !last_stall);
    end
  endtask

  initial begin
    rst = 1'b1; rr_valid = 1'b0; rr_rs1 = '0; rr_rs2 = '0; rr_rd = '0;
    rr_we = 1'b0; rr_is_load = 1'b0; hold = 1'b0; flush = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_distance();
    test_priority();
    test_load_use();
    test_flush_hold();
    test_reset_mid_stall();
    test_x0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
